usb_tx_pkt_ctrl: RTL and testbench
==================================

USB_TX_PKT_CTRL -- requirements
Module: usb_tx_pkt_ctrl

Interface
REQ-001 Parameters SHALL be:
- MAX_DATA_BYTES, 64, largest DATA payload accepted.
- SIZE_W, 7, width of tx_packet_data_size.
- SYNC_BYTE, 8'h80, sync byte presented to the shifter.

REQ-002 Ports SHALL be (reset n_rst, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_packet  in  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 invalid
- tx_packet_data_size  in  SIZE_W  payload byte count
- tx_packet_data  in  8  head byte of the first-word-fall-through TX buffer
- get_tx_packet  out  1  buffer pop strobe
- byte_complete  in  1  shifter/encoder finished the current byte or EOP
- load_enable  out  1  one-cycle load strobe for data_pts
- data_pts  out  8  byte to the parallel-to-serial shifter
- eop  out  1  encoder drives EOP while high
- tx_busy  out  1  high outside IDLE
- tx_done  out  1  one-cycle completion pulse
- tx_error  out  1  one-cycle rejected-request pulse
- state_val  out  4  current state encoding

Function
REQ-003 The FSM SHALL have these states: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, WAIT_CLR. All outputs SHALL be registered.
REQ-004 In IDLE with tx_packet in 1..5, the block SHALL latch the code and size, then enter SYNC on the next edge. tx_packet changes after the latch SHALL be ignored.
REQ-005 On entry to each byte state, load_enable SHALL pulse for exactly one cycle with data_pts valid. The FSM SHALL then hold until byte_complete=1 and advance on that edge.
REQ-006 Byte values SHALL be:
- SYNC: SYNC_BYTE.
- PID: {~pid,pid}, giving DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E.
REQ-007 Sequence SHALL be:
- DATA0/1: SYNC, PID, DATA×size, CRC_LO, CRC_HI, EOP.
- Handshakes: SYNC, PID, EOP.
- size=0: PID goes directly to CRC_LO.
REQ-008 Each DATA byte SHALL pulse get_tx_packet in the same cycle as its load_enable, with data_pts=tx_packet_data.
REQ-009 The byte counter SHALL be $clog2(MAX_DATA_BYTES+1) bits wide, cleared at latch and incremented per DATA load. The last DATA byte is the one where count+1==size.
REQ-010 CRC16 SHALL use reflected polynomial 0xA001 with init 0xFFFF, be updated per DATA byte, and be transmitted inverted, low byte first.
REQ-011 In EOP, eop SHALL be 1 and load_enable 0. On byte_complete the block SHALL pulse tx_done and enter WAIT_CLR.
REQ-012 WAIT_CLR SHALL hold until tx_packet==0, then return to IDLE. This prevents retransmission of a held request.
REQ-013 In IDLE, a request with code 6-7 or size>MAX_DATA_BYTES (DATA codes only) SHALL pulse tx_error, enter WAIT_CLR, and transmit nothing.
REQ-014 byte_complete in IDLE or WAIT_CLR SHALL be ignored.

Reset
REQ-015 n_rst low SHALL force IDLE at any time, including mid-packet. All outputs SHALL be 0, the byte counter 0, and CRC 0xFFFF.

Configuration
REQ-016 With USB_TX_STALL_EN defined, code 5 SHALL send STALL. Without it, code 5 SHALL be treated as invalid per REQ-013.

Structure
REQ-017 Package usb_tx_pkg SHALL hold:
- tx_packet code constants
- PID nibble constants
- the state enum
- the default SYNC byte
REQ-018 CRC16 byte update SHALL be sub-module usb_crc16 (clear, enable, data[7:0], crc[15:0]).

Verification
REQ-019 ACK request, byte_complete 4 cycles after each load: loads 80, D2, then eop. After the final byte_complete, tx_done pulses once.
REQ-020 DATA0 size=0: loads 80, C3, 00, 00, then EOP. get_tx_packet never pulses.
REQ-021 DATA1 size=3 with buffer 01, 02, 03: loads 80, 4B, 01, 02, 03, then CRC bytes matching the reference model. get_tx_packet pulses 3 times.
REQ-022 DATA0 size=65: tx_error pulses and load_enable stays 0. Holding tx_packet stays in WAIT_CLR; clearing it returns to IDLE.
REQ-023 Reset during the second DATA byte: all outputs drop to 0. A following ACK request transmits normally.
REQ-024 STALL request with and without USB_TX_STALL_EN: with it, 1E is sent; without it, tx_error pulses.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB transmit packet controller:
//   - tx_packet request codes presented by the protocol layer
//   - 4-bit PID values (the transmitted PID byte is {~pid, pid})
//   - packet controller state encoding (IDLE must stay 0: reset drives
//     state_val to 0)
//   - default SYNC byte and the CRC16 byte-update helper
// -----------------------------------------------------------------------------
package usb_tx_pkg;

  localparam logic [2:0] TX_NONE  = 3'd0;
  localparam logic [2:0] TX_DATA0 = 3'd1;
  localparam logic [2:0] TX_DATA1 = 3'd2;
  localparam logic [2:0] TX_ACK   = 3'd3;
  localparam logic [2:0] TX_NAK   = 3'd4;
  localparam logic [2:0] TX_STALL = 3'd5;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'h80;
  localparam logic [15:0] CRC16_POLY        = 16'hA001;
  localparam logic [15:0] CRC16_INIT        = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SYNC     = 4'd1,
    ST_PID      = 4'd2,
    ST_DATA     = 4'd3,
    ST_CRC_LO   = 4'd4,
    ST_CRC_HI   = 4'd5,
    ST_EOP      = 4'd6,
    ST_WAIT_CLR = 4'd7
  } tx_state_e;

  // Maps a request code to its PID nibble; unsupported codes never reach here.
  function automatic logic [3:0] code_to_pid(input logic [2:0] code);
    case (code)
      TX_DATA0: return PID_DATA0;
      TX_DATA1: return PID_DATA1;
      TX_ACK:   return PID_ACK;
      TX_NAK:   return PID_NAK;
      default:  return PID_STALL;
    endcase
  endfunction

  // Reflected CRC16 over one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_tx_pkt_ctrl_crc16.sv
// -----------------------------------------------------------------------------
// usb_crc16
// Byte-wide CRC16 accumulator (reflected poly 0xA001, init 0xFFFF).
// Ports:
//   clk, n_rst  clock / asynchronous active-low reset (crc -> 0xFFFF)
//   clear_i     reload 0xFFFF (has priority over enable_i)
//   enable_i    fold data_i into the running CRC this cycle
//   data_i      byte to accumulate
//   crc_o       running CRC (not inverted)
// -----------------------------------------------------------------------------
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = CRC16_INIT;
    end else if (enable_i) begin
      crc_d = crc16_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// usb_tx_pkt_ctrl
// Sequences one USB packet (SYNC, PID, optional DATA payload + CRC16, EOP)
// into a byte-serial shifter/encoder.
// Build option: define USB_TX_STALL_EN to allow STALL handshakes (code 5);
// without it code 5 is rejected like codes 6-7.
// Ports:
//   clk, n_rst            clock / asynchronous active-low reset
//   tx_packet             request code (0 none, 1 DATA0, 2 DATA1, 3 ACK,
//                         4 NAK, 5 STALL)
//   tx_packet_data_size   payload byte count for DATA requests
//   tx_packet_data        head of the first-word-fall-through TX buffer
//   get_tx_packet         buffer pop strobe (with each DATA byte load)
//   byte_complete         shifter finished current byte / EOP
//   load_enable, data_pts one-cycle load strobe and byte for the shifter
//   eop                   encoder drives EOP while high
//   tx_busy               high outside IDLE
//   tx_done, tx_error     one-cycle completion / rejection pulses
//   state_val             current state encoding
// -----------------------------------------------------------------------------
module usb_tx_pkt_ctrl
  import usb_tx_pkg::*;
#(
  parameter int         MAX_DATA_BYTES = 64,
  parameter int         SIZE_W         = 7,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        tx_packet,
  input  logic [SIZE_W-1:0] tx_packet_data_size,
  input  logic [7:0]        tx_packet_data,
  output logic              get_tx_packet,
  input  logic              byte_complete,
  output logic              load_enable,
  output logic [7:0]        data_pts,
  output logic              eop,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error,
  output logic [3:0]        state_val
);

  localparam int CNT_W = $clog2(MAX_DATA_BYTES + 1);

  function automatic logic code_supported(input logic [2:0] code);
    case (code)
      TX_DATA0, TX_DATA1, TX_ACK, TX_NAK: return 1'b1;
`ifdef USB_TX_STALL_EN
      TX_STALL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic code_is_data(input logic [2:0] code);
    return (code == TX_DATA0) || (code == TX_DATA1);
  endfunction

  tx_state_e         state_q;
  logic [2:0]        code_q;
  logic [SIZE_W-1:0] size_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;
  logic              load_q;
  logic [7:0]        data_q;
  logic              get_q;
  logic              eop_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [15:0]       crc;
  logic              byte_done;
  logic              req_bad;

  // A completion seen in the load cycle itself is ignored: the CRC folds
  // each DATA byte in the cycle after its load, so the earliest legal
  // advance is one cycle after load_enable.
  assign byte_done = byte_complete && !load_q;

  assign req_bad = !code_supported(tx_packet) ||
                   (code_is_data(tx_packet) &&
                    (32'(tx_packet_data_size) > MAX_DATA_BYTES));

  usb_crc16 u_crc (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear_i  (state_q == ST_IDLE),
    .enable_i (get_q),
    .data_i   (data_q),
    .crc_o    (crc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      code_q  <= TX_NONE;
      size_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= 8'h00;
      get_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      load_q <= 1'b0;
      get_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (tx_packet != TX_NONE) begin
            busy_q <= 1'b1;
            if (req_bad) begin
              err_q   <= 1'b1;
              state_q <= ST_WAIT_CLR;
            end else begin
              code_q  <= tx_packet;
              size_q  <= tx_packet_data_size;
              cnt_q   <= '0;
              load_q  <= 1'b1;
              data_q  <= SYNC_BYTE;
              state_q <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (byte_done) begin
            load_q  <= 1'b1;
            data_q  <= {~code_to_pid(code_q), code_to_pid(code_q)};
            state_q <= ST_PID;
          end
        end
        ST_PID, ST_DATA: begin
          if (byte_done) begin
            if (!code_is_data(code_q)) begin
              eop_q   <= 1'b1;
              state_q <= ST_EOP;
            end else if ((state_q == ST_PID && size_q == '0) ||
                         (state_q == ST_DATA && last_q)) begin
              load_q  <= 1'b1;
              data_q  <= ~crc[7:0];
              state_q <= ST_CRC_LO;
            end else begin
              load_q  <= 1'b1;
              get_q   <= 1'b1;
              data_q  <= tx_packet_data;
              cnt_q   <= cnt_q + 1'b1;
              last_q  <= (32'(cnt_q) + 32'd1) == 32'(size_q);
              state_q <= ST_DATA;
            end
          end
        end
        ST_CRC_LO: begin
          if (byte_done) begin
            load_q  <= 1'b1;
            data_q  <= ~crc[15:8];
            state_q <= ST_CRC_HI;
          end
        end
        ST_CRC_HI: begin
          if (byte_done) begin
            eop_q   <= 1'b1;
            state_q <= ST_EOP;
          end
        end
        ST_EOP: begin
          if (byte_done) begin
            eop_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          // Request must be withdrawn before another can be accepted.
          if (tx_packet == TX_NONE) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          eop_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign get_tx_packet = get_q;
  assign load_enable   = load_q;
  assign data_pts      = data_q;
  assign eop           = eop_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign tx_error      = err_q;
  assign state_val     = state_q;

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_pkt_ctrl
// Self-checking bench for usb_tx_pkt_ctrl. A packet-level model builds the
// expected byte stream (SYNC, PID, payload, inverted CRC) per request; a
// negedge monitor checks every load against it. A responder returns
// byte_complete a programmable/random number of cycles after each load/EOP.
// -----------------------------------------------------------------------------
module tb_usb_tx_pkt_ctrl;

  localparam int MAXB = 64;
`ifdef USB_TX_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] tx_size = 7'd0;
  logic [7:0] tx_data = 8'h00;
  logic       byte_complete = 1'b0;
  logic       get_tx_packet, load_enable, eop, tx_busy, tx_done, tx_error;
  logic [7:0] data_pts;
  logic [3:0] state_val;

  usb_tx_pkt_ctrl dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .tx_packet           (tx_packet),
    .tx_packet_data_size (tx_size),
    .tx_packet_data      (tx_data),
    .get_tx_packet       (get_tx_packet),
    .byte_complete       (byte_complete),
    .load_enable         (load_enable),
    .data_pts            (data_pts),
    .eop                 (eop),
    .tx_busy             (tx_busy),
    .tx_done             (tx_done),
    .tx_error            (tx_error),
    .state_val           (state_val)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] buf_q[$];
  logic [8:0] exp_q[$];   // {expected get_tx_packet, expected data_pts}
  int n_loads = 0, n_gets = 0, n_done = 0, n_err = 0, n_eop = 0;
  logic eop_prev = 1'b0;

  int fixed_delay = 0;
  bit spurious = 1'b0;
  int cd = 0;
  bit eop_armed = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [7:0] pid_tab(input logic [2:0] code);
    case (code)
      3'd1: return 8'hC3;
      3'd2: return 8'h4B;
      3'd3: return 8'hD2;
      3'd4: return 8'h5A;
      default: return 8'h1E;
    endcase
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    bit fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  function automatic bit req_ok(input logic [2:0] code, input int size);
    bit is_data;
    is_data = (code == 3'd1) || (code == 3'd2);
    if (code == 3'd0 || code > 3'd5) return 1'b0;
    if (code == 3'd5 && !STALL_EN) return 1'b0;
    if (is_data && size > MAXB) return 1'b0;
    return 1'b1;
  endfunction

  task automatic build_exp(input logic [2:0] code, input int size, input bit seq);
    logic [15:0] c;
    logic [7:0] b;
    exp_q.delete();
    buf_q.delete();
    if (req_ok(code, size)) begin
      exp_q.push_back({1'b0, 8'h80});
      exp_q.push_back({1'b0, pid_tab(code)});
      if (code == 3'd1 || code == 3'd2) begin
        c = 16'hFFFF;
        for (int i = 0; i < size; i++) begin
          b = seq ? 8'(i + 1) : 8'($urandom);
          buf_q.push_back(b);
          exp_q.push_back({1'b1, b});
          c = crc_model(c, b);
        end
        exp_q.push_back({1'b0, ~c[7:0]});
        exp_q.push_back({1'b0, ~c[15:8]});
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / compare ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (load_enable) begin
      total++;
      n_loads++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_load: data_pts=%h get=%b, no load required", data_pts, get_tx_packet);
      end else begin
        e = exp_q.pop_front();
        if (data_pts !== e[7:0] || get_tx_packet !== e[8] || eop !== 1'b0) begin
          bad++;
          $display("FAIL load_byte: data_pts=%h get=%b eop=%b, required %h get=%b eop=0",
                   data_pts, get_tx_packet, eop, e[7:0], e[8]);
        end
      end
    end else if (get_tx_packet) begin
      total++;
      bad++;
      $display("FAIL stray_get: get_tx_packet=1 without load_enable, required 0");
    end
    if (get_tx_packet) begin
      n_gets++;
      if (buf_q.size() > 0) buf_q.delete(0);
    end
    tx_data = (buf_q.size() > 0) ? buf_q[0] : 8'h00;
    if (tx_done) n_done++;
    if (tx_error) n_err++;
    if (eop && !eop_prev) n_eop++;
    eop_prev = eop;
  end

  // ---------------- byte_complete responder ----------------
  always @(negedge clk) begin
    byte_complete = 1'b0;
    if (!n_rst) begin
      cd = 0;
      eop_armed = 1'b0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) byte_complete = 1'b1;
    end else if (load_enable || (eop && !eop_armed)) begin
      cd = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 5));
      if (eop) eop_armed = 1'b1;
    end else if (spurious) begin
      byte_complete = 1'($urandom_range(0, 1));
    end
    if (!eop) eop_armed = 1'b0;
  end

  // ---------------- one request, start to IDLE ----------------
  task automatic run_txn(input logic [2:0] code, input int size, input bit seq, input bit mut);
    int d0, e0, g0, p0, l0, cyc;
    bit ok, is_data;
    ok = req_ok(code, size);
    is_data = (code == 3'd1) || (code == 3'd2);
    build_exp(code, size, seq);
    d0 = n_done; e0 = n_err; g0 = n_gets; p0 = n_eop;
    spurious = 1'b0;
    @(posedge clk); #1;
    tx_packet = code;
    tx_size = 7'(size);
    cyc = 0;
    while (n_done == d0 && n_err == e0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (mut && cyc == 3) begin
        tx_packet = 3'($urandom_range(1, 7));
        tx_size = 7'($urandom);
      end
    end
    chk("completion_timeout", (cyc < 3000) ? 32'd1 : 32'd0, 32'd1);
    chk("bytes_left", exp_q.size(), 32'd0);
    chk("get_count", n_gets - g0, (ok && is_data) ? size : 0);
    chk("eop_count", n_eop - p0, ok ? 32'd1 : 32'd0);
    // Held request: must sit in WAIT_CLR, ignoring byte_complete.
    l0 = n_loads;
    spurious = 1'b1;
    repeat (5) @(negedge clk);
    chk("wait_clr_busy", tx_busy, 32'd1);
    chk("wait_clr_no_load", n_loads - l0, 32'd0);
    chk("done_pulses", n_done - d0, ok ? 32'd1 : 32'd0);
    chk("error_pulses", n_err - e0, ok ? 32'd0 : 32'd1);
    tx_packet = 3'd0;
    repeat (5) @(negedge clk);
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", tx_busy, 32'd0);
    chk("idle_state", state_val, 32'd0);
    chk("idle_no_load", n_loads - l0, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    int g0, cyc;
    // Model pins
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = crc_model(c, 8'(8'h31 + i));
    c = ~c;
    chk("model_crc_123456789", c, 32'hB4C8);
    chk("model_pid_data0", pid_tab(3'd1), 32'hC3);
    chk("model_pid_ack", pid_tab(3'd3), 32'hD2);
    chk("model_pid_stall", pid_tab(3'd5), 32'h1E);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {get_tx_packet, load_enable, data_pts, eop, tx_busy, tx_done, tx_error, state_val}, 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed
    fixed_delay = 4;
    run_txn(3'd3, 0, 1'b0, 1'b0);          // ACK
    fixed_delay = 0;
    run_txn(3'd1, 0, 1'b0, 1'b0);          // DATA0 empty -> 80 C3 00 00
    run_txn(3'd2, 3, 1'b1, 1'b1);          // DATA1 01 02 03, request changed mid-packet
    run_txn(3'd1, 65, 1'b0, 1'b0);         // oversize -> error
    run_txn(3'd2, 64, 1'b0, 1'b0);         // largest legal payload
    run_txn(3'd4, 100, 1'b0, 1'b0);        // NAK, size ignored
    run_txn(3'd5, 0, 1'b0, 1'b0);          // STALL (build-dependent)
    run_txn(3'd6, 2, 1'b0, 1'b0);
    run_txn(3'd7, 0, 1'b0, 1'b0);

    // Reset during the second DATA byte
    build_exp(3'd1, 4, 1'b0);
    g0 = n_gets;
    @(posedge clk); #1;
    tx_packet = 3'd1;
    tx_size = 7'd4;
    cyc = 0;
    while (n_gets - g0 < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("second_byte_reached", (cyc < 500) ? 32'd1 : 32'd0, 32'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("midpkt_reset_outputs", {get_tx_packet, load_enable, data_pts, eop, tx_busy, tx_done, tx_error, state_val}, 32'd0);
    tx_packet = 3'd0;
    exp_q.delete();
    buf_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    run_txn(3'd3, 0, 1'b0, 1'b0);
    run_txn(3'd1, 5, 1'b0, 1'b0);          // CRC restarts from init after reset

    // Randomized
    for (int t = 0; t < 40; t++) begin
      logic [2:0] code;
      int size;
      code = 3'($urandom_range(1, 7));
      size = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127)) : int'($urandom_range(0, 12));
      fixed_delay = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_txn(code, size, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
